// File: rtl/kg_axil_write_master.sv
// Turns Kugelblitz register-file address/data handoffs into single AXI4-Lite writes.
// Optional: define KG_WR_RESP_CHECK_EN to count non-OKAY write responses in err_count.
module kg_axil_write_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] kg_address_valid,
    input  logic [DATA_WIDTH-1:0] kg_address,
    input  logic [DATA_WIDTH-1:0] kg_data_valid,
    input  logic [DATA_WIDTH-1:0] kg_data,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    input  logic                  clr_status,
    output logic                  busy,
    output logic                  overflow,
    output logic [7:0]            drop_count,
    output logic [7:0]            err_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic a_prev_q, d_prev_q;
    logic a_edge, d_edge;
    logic pend_a_q, pend_a_d;
    logic pend_d_q, pend_d_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic pair, push, pop, ovf_set, drop_inc;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic fifo_empty, fifo_full;
    logic [ENT_W-1:0] head;

    logic awvalid_q, awvalid_d;
    logic wvalid_q, wvalid_d;
    logic bready_q, bready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic overflow_q;
    logic [7:0] drop_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];

    // A replaced half-pair counts as a drop; it cannot coincide with a push.
    always_comb begin
        a_edge      = kg_address_valid[0] & ~a_prev_q;
        d_edge      = kg_data_valid[0] & ~d_prev_q;
        pair        = pend_a_q & pend_d_q;
        push        = pair & ~fifo_full;
        ovf_set     = pair & fifo_full;
        drop_inc    = ovf_set;
        pend_a_d    = pend_a_q & ~pair;
        pend_d_d    = pend_d_q & ~pair;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        if (a_edge) begin
            pend_a_d    = 1'b1;
            pend_addr_d = kg_address[ADDR_WIDTH-1:0];
            if (pend_a_q & ~pend_d_q) drop_inc = 1'b1;
        end
        if (d_edge) begin
            pend_d_d    = 1'b1;
            pend_data_d = kg_data;
            if (pend_d_q & ~pend_a_q) drop_inc = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    awaddr_d  = head[ENT_W-1:DATA_WIDTH];
                    wdata_d   = head[DATA_WIDTH-1:0];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axil_wready) wvalid_d = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (m_axil_bvalid) begin
                    bready_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_prev_q    <= 1'b0;
            d_prev_q    <= 1'b0;
            pend_a_q    <= 1'b0;
            pend_d_q    <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_prev_q    <= kg_address_valid[0];
            d_prev_q    <= kg_data_valid[0];
            pend_a_q    <= pend_a_d;
            pend_d_q    <= pend_d_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= {pend_addr_q, pend_data_q};
    end

    always_ff @(posedge clk) begin
        if (rst || clr_status) begin
            overflow_q <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            if (ovf_set) overflow_q <= 1'b1;
            if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

`ifdef KG_WR_RESP_CHECK_EN
    logic [7:0] err_q;
    logic err_inc;
    logic unused_bits;

    assign err_inc = bready_q & m_axil_bvalid & (m_axil_bresp != 2'b00);

    always_ff @(posedge clk) begin
        if (rst || clr_status) begin
            err_q <= 8'h00;
        end else if (err_inc && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count   = err_q;
    assign unused_bits = ^{kg_address_valid[DATA_WIDTH-1:1],
                           kg_data_valid[DATA_WIDTH-1:1],
                           kg_address[DATA_WIDTH-1:ADDR_WIDTH]};
`else
    logic unused_bits;

    assign err_count   = 8'h00;
    assign unused_bits = ^{kg_address_valid[DATA_WIDTH-1:1],
                           kg_data_valid[DATA_WIDTH-1:1],
                           kg_address[DATA_WIDTH-1:ADDR_WIDTH],
                           m_axil_bresp};
`endif

    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = '1;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign overflow       = overflow_q;
    assign drop_count     = drop_q;
    assign busy           = !fifo_empty || (state_q != IDLE) || pend_a_q || pend_d_q;

endmodule

// File: doc/kg_axil_write_master.md
# kg_axil_write_master

Consumes the address/data handoff registers produced by the Kugelblitz AXI-Lite register file and turns each software-issued (address, data) pair into one AXI4-Lite write on a master port toward Kugelblitz core memory. The block sits directly downstream of the register file.
- Detects rising edges of the valid flags.
- Pairs each address with its data.
- Buffers pairs in a small FIFO.
- Issues one AXI-Lite write per pair and reports drops and errors.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI-Lite data width; also the width of the kg_* inputs.
- ADDR_WIDTH, 16, master address width; the low ADDR_WIDTH bits of kg_address are used.
- STRB_WIDTH, DATA_WIDTH/8, wstrb width.
- FIFO_DEPTH, 4, command FIFO depth; must be a power of 2, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- kg_address_valid  in  DATA_WIDTH  bit 0 is the address flag; other bits are ignored
- kg_address  in  DATA_WIDTH  target address
- kg_data_valid  in  DATA_WIDTH  bit 0 is the data flag; other bits are ignored
- kg_data  in  DATA_WIDTH  write data
- m_axil_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_WIDTH/3/1/1  write address channel; awprot is fixed at 3'b000
- m_axil_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/STRB_WIDTH/1/1  write data channel; wstrb is all ones
- m_axil_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
- clr_status  in  1  single-cycle pulse; clears sticky flags and counters
- busy  out  1  high when the FIFO is non-empty, the FSM is not IDLE, or a pending half-pair is held
- overflow  out  1  sticky; set when a command is dropped
- drop_count  out  8  saturating count of dropped or overwritten commands
- err_count  out  8  saturating count of non-OKAY write responses

## Operation
- Edge detect: the previous value of bit 0 of each valid input is registered. A 0->1 transition captures the sampled value into a pending-address or pending-data register and sets the matching pending flag.
- Pairing: when both pending flags are set, {addr, data} is pushed to the FIFO and both flags clear in the same cycle.
- Simultaneous address and data edges pair in the same cycle.
- A new address edge while an address is already pending and data is not yet present:
  - the pending address is replaced;
  - drop_count is incremented.
- A new data edge while data is already pending behaves the same way: the pending data is replaced and drop_count is incremented.
- FIFO full at the time of a push: the command is discarded, overflow is set and drop_count is incremented. The FIFO contents are unchanged.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head, load awaddr and wdata, assert awvalid and wvalid, and go to SEND.
  - SEND: awvalid drops after its aw handshake; wvalid drops after its w handshake. The two channels complete independently, in either order or in the same cycle. When both are complete, assert bready and go to RESP.
  - RESP: on bvalid && bready, deassert bready and return to IDLE.
- Outstanding transactions: at most one.
- awaddr and wdata are stable from assertion until their handshake.
- clr_status takes priority over a same-cycle increment: the counters become 0 and overflow becomes 0.
- Counters saturate at 8'hFF.

## Timing
- Reset values:
  - awvalid, wvalid, bready: 0
  - awaddr, wdata: 0
  - busy, overflow: 0
  - drop_count, err_count: 0
  - pending flags, previous-valid registers, FIFO pointers: 0
- Reset mid-transaction: the transaction is abandoned; all channel outputs are 0 in the cycle after rst is sampled.
- Latency:
  - The later of the two rising edges is sampled at cycle N.
  - The FIFO write happens at N+1.
  - awvalid and wvalid assert at N+2, provided the FSM is IDLE and the FIFO was empty.
- IDLE to SEND takes 1 cycle. Back-to-back commands have a minimum spacing of 1 IDLE cycle between bvalid handshake and the next awvalid.
- The FIFO supports a push and a pop in the same cycle. When full, the pop frees no slot for a push in that cycle; that push is treated as overflow.

## Configuration
- KG_WR_RESP_CHECK_EN:
  - Defined: any bresp != 2'b00 increments err_count.
  - Undefined: bresp is ignored and err_count is tied to 0.

## Test plan
- Address edge with kg_address=0x0000_0040, then data edge 3 cycles later with kg_data=0xDEAD_BEEF. Required: awaddr=0x0040, wdata=0xDEADBEEF, awvalid and wvalid high 2 cycles after the data edge; exactly one write.
- Both edges in the same cycle, awready delayed 4 cycles while wready is immediate. Required: wvalid drops after 1 cycle; awvalid is held with a stable address; bready rises only after both handshakes.
- Two address edges (0x10, then 0x20) before a single data edge 0x5. Required: one write to 0x20 with data 0x5; drop_count=1.
- Bvalid held low, FIFO_DEPTH+2 pairs pushed. Required: overflow=1; drop_count=1, since the 1st pair is in flight and the next FIFO_DEPTH fill the FIFO. After bvalid resumes, FIFO_DEPTH+1 writes complete in order.
- With KG_WR_RESP_CHECK_EN defined, bresp=2'b10 on two writes, then clr_status pulse. Required: err_count=2, then 0 the following cycle.
- rst asserted while in SEND with awvalid high. Required: all outputs 0 the next cycle; a subsequent pair is written normally.
